// File: rtl/sdram_clk_sup_pkg.sv
// Shared types and constants for the SDRAM clock-manager lock supervisor.
package sdram_clk_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } sup_state_e;

    localparam int LOSS_CNT_W = 8;
    localparam int RETRY_W    = 2;

    // Number of bits needed to hold values 0..value-1 (at least 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_lock_sync.sv
// Two-flop synchroniser for the raw LOCKED lines of the clock managers.
module sdram_lock_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives a clean level two edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdram_clk_supervisor.sv
// Lock supervisor and reset sequencer for the SDRAM clock-manager channels.
// Sequence: RESET -> WAIT_LOCK -> STABLE -> RUN, bounded retries, sticky FAIL.
// Optional build macro SDRAM_CLK_SUP_AUTO_RECOVER_EN: a lock loss in RUN
// re-sequences through RESET instead of landing in FAIL.
module sdram_clk_supervisor
    import sdram_clk_sup_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 256,
    parameter int STABLE_CYCLES = 16,
    parameter int MAX_RETRY     = 2,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     locked_in,
    input  logic                  clear_fail,
    output logic [NUM_CH-1:0]     dcm_rst,
    output logic                  ready,
    output logic                  phy_clk_en,
    output logic                  fail,
    output logic [RETRY_W-1:0]    retry_cnt,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_CYC_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC   = (MAX_CYC_A > STABLE_CYCLES) ? MAX_CYC_A : STABLE_CYCLES;

    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    // Reject configurations whose timers or channel count cannot work.
    generate
        if (clog2(MAX_CYC) > CNT_W) begin : g_bad_cnt_w
            $error("CNT_W too narrow for the configured cycle counts");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("NUM_CH must be in 1..8");
        end
    endgenerate

    sup_state_e            state;
    sup_state_e            next_state;
    logic [CNT_W-1:0]      timer;
    logic [CNT_W-1:0]      timer_next;
    logic [RETRY_W-1:0]    retry_next;
    logic [NUM_CH-1:0]     mask;
    logic [NUM_CH-1:0]     locked_s;
    logic                  all_locked;
    logic                  load_mask;
    logic                  loss_event;
    logic                  failure;

    sdram_lock_sync #(
        .WIDTH (NUM_CH)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked_in),
        .q   (locked_s)
    );

    // Channels outside the mask are treated as locked.
    assign all_locked = &(locked_s | ~mask);

    // State, timer, retry counter and channel mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RESET;
            timer     <= '0;
            retry_cnt <= '0;
            mask      <= '0;
        end else begin
            state     <= next_state;
            timer     <= timer_next;
            retry_cnt <= retry_next;
            if (load_mask) begin
                mask <= ch_enable;
            end
        end
    end

    // Next-state logic; a failure is resolved after the per-state decision.
    always_comb begin
        next_state = state;
        timer_next = timer;
        retry_next = retry_cnt;
        load_mask  = 1'b0;
        loss_event = 1'b0;
        failure    = 1'b0;
        case (state)
            ST_RESET: begin
                if (timer == RST_TC) begin
                    timer_next = '0;
                    if (ch_enable != '0) begin
                        load_mask  = 1'b1;
                        next_state = ST_WAIT_LOCK;
                    end
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (all_locked) begin
                    next_state = ST_STABLE;
                    timer_next = '0;
                end else if (timer == LOCK_TC) begin
                    failure = 1'b1;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!all_locked) begin
                    failure = 1'b1;
                end else if (timer == STABLE_TC) begin
                    next_state = ST_RUN;
                    timer_next = '0;
                    retry_next = '0;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!all_locked) begin
                    loss_event = 1'b1;
                    timer_next = '0;
`ifdef SDRAM_CLK_SUP_AUTO_RECOVER_EN
                    next_state = ST_RESET;
`else
                    next_state = ST_FAIL;
`endif
                end
            end
            ST_FAIL: begin
                if (clear_fail) begin
                    next_state = ST_RESET;
                    timer_next = '0;
                    retry_next = '0;
                end
            end
            default: begin
                next_state = ST_RESET;
                timer_next = '0;
            end
        endcase
        if (failure) begin
            timer_next = '0;
            if (retry_cnt == RETRY_MAX) begin
                next_state = ST_FAIL;
            end else begin
                retry_next = retry_cnt + RETRY_W'(1);
                next_state = ST_RESET;
            end
        end
    end

    // Clock-manager resets: only enabled channels are released, and only while sequencing or running.
    always_comb begin
        dcm_rst = '1;
        case (state)
            ST_WAIT_LOCK, ST_STABLE, ST_RUN: dcm_rst = ~mask;
            default:                         dcm_rst = '1;
        endcase
    end

    // Status flags are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready      <= 1'b0;
            phy_clk_en <= 1'b0;
            fail       <= 1'b0;
        end else begin
            ready      <= (next_state == ST_RUN);
            phy_clk_en <= (next_state == ST_RUN);
            fail       <= (next_state == ST_FAIL);
        end
    end

    // Saturating count of lock losses seen while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (loss_event && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sdram_clk_supervisor.sv
// Scoreboard bench for sdram_clk_supervisor (default parameters).
module tb_sdram_clk_supervisor;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [1:0] ch_enable  = 2'b11;
    logic [1:0] locked_in  = 2'b00;
    logic       clear_fail = 1'b0;
    logic [1:0] dcm_rst;
    logic       ready;
    logic       phy_clk_en;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

`ifdef SDRAM_CLK_SUP_AUTO_RECOVER_EN
    localparam logic LOSS_FAIL = 1'b0;
`else
    localparam logic LOSS_FAIL = 1'b1;
`endif

    typedef struct {
        int         at_cyc;
        string      name;
        logic [1:0] dcm;
        logic       rdy;
        logic       fl;
        logic [1:0] rc;
        logic [7:0] lc;
    } exp_t;

    exp_t sb[$];

    sdram_clk_supervisor dut (
        .clk           (clk),
        .rst           (rst),
        .ch_enable     (ch_enable),
        .locked_in     (locked_in),
        .clear_fail    (clear_fail),
        .dcm_rst       (dcm_rst),
        .ready         (ready),
        .phy_clk_en    (phy_clk_en),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [1:0] d, input logic r,
                               input logic f, input logic [1:0] rc, input logic [7:0] lc);
        checks++;
        if (dcm_rst !== d || ready !== r || phy_clk_en !== r || fail !== f ||
            retry_cnt !== rc || lock_loss_cnt !== lc) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got dcm_rst=%b ready=%b phy_clk_en=%b fail=%b retry_cnt=%0d lock_loss_cnt=%0d, expected dcm_rst=%b ready=%b phy_clk_en=%b fail=%b retry_cnt=%0d lock_loss_cnt=%0d",
                     nm, cyc, dcm_rst, ready, phy_clk_en, fail, retry_cnt, lock_loss_cnt,
                     d, r, r, f, rc, lc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [1:0] lk);
        ch_enable = en;
        locked_in = lk;
    endtask

    task automatic expect_at(input int c, input string nm, input logic [1:0] d, input logic r,
                             input logic f, input logic [1:0] rc, input logic [7:0] lc);
        exp_t e;
        e.at_cyc = c;
        e.name   = nm;
        e.dcm    = d;
        e.rdy    = r;
        e.fl     = f;
        e.rc     = rc;
        e.lc     = lc;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut(output int r);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
    endtask

    // Monitor: at each falling edge, pop every expectation due this cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
                e = sb.pop_front();
                if (e.at_cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: sample missed, taken at cycle %0d but required at %0d",
                             e.name, cyc, e.at_cyc);
                end else begin
                    checkOutput(e.name, e.dcm, e.rdy, e.fl, e.rc, e.lc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int k;

        // Bring-up, then lock loss in RUN.
        applyStimulus(2'b11, 2'b00);
        reset_dut(r);
        expect_at(r,      "reset_state",   2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 7,  "rst_pulse_hi",  2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 8,  "rst_pulse_lo",  2'b00, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 30, "bringup_wait",  2'b00, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 31, "bringup_ready", 2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        expect_at(r + 42, "loss_pre",      2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        expect_at(r + 43, "loss_post",     2'b11, 1'b0, LOSS_FAIL, 2'd0, 8'd1);
        wait_until(r + 12);
        applyStimulus(2'b11, 2'b11);
        wait_until(r + 40);
        applyStimulus(2'b11, 2'b10);
        wait_until(r + 45);

        // Lock timeout on every attempt, FAIL, then clear_fail.
        applyStimulus(2'b11, 2'b00);
        reset_dut(r);
        expect_at(r + 263, "timeout1_wait",  2'b00, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 264, "timeout1_retry", 2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(r + 528, "timeout2_retry", 2'b11, 1'b0, 1'b0, 2'd2, 8'd0);
        expect_at(r + 791, "timeout3_wait",  2'b00, 1'b0, 1'b0, 2'd2, 8'd0);
        expect_at(r + 792, "fail_entry",     2'b11, 1'b0, 1'b1, 2'd2, 8'd0);
        expect_at(r + 796, "clear_fail",     2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(r + 795);
        clear_fail = 1'b1;
        wait_until(r + 796);
        clear_fail = 1'b0;
        wait_until(r + 798);

        // One-cycle glitch on ch0 during STABLE, then a clean retry.
        applyStimulus(2'b11, 2'b11);
        reset_dut(r);
        expect_at(r + 21, "glitch_stable", 2'b00, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 22, "glitch_retry",  2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(r + 46, "retry_pre_run", 2'b00, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(r + 47, "retry_run",     2'b00, 1'b1, 1'b0, 2'd0, 8'd0);
        wait_until(r + 19);
        applyStimulus(2'b11, 2'b10);
        wait_until(r + 20);
        applyStimulus(2'b11, 2'b11);
        wait_until(r + 48);

        // Asynchronous reset in the middle of STABLE.
        applyStimulus(2'b11, 2'b00);
        reset_dut(r);
        expect_at(r + 264, "d_retry",  2'b11, 1'b0, 1'b0, 2'd1, 8'd0);
        expect_at(r + 279, "d_stable", 2'b00, 1'b0, 1'b0, 2'd1, 8'd0);
        wait_until(r + 264);
        applyStimulus(2'b11, 2'b11);
        wait_until(r + 280);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);

        // Channel mask: ch0 only, then no channels enabled.
        applyStimulus(2'b01, 2'b01);
        reset_dut(r);
        expect_at(r + 8,  "mask_wait",    2'b10, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 24, "mask_pre_run", 2'b10, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 25, "mask_run",     2'b10, 1'b1, 1'b0, 2'd0, 8'd0);
        wait_until(r + 26);
        applyStimulus(2'b00, 2'b00);
        reset_dut(r);
        expect_at(r + 8,   "mask_none_8",   2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 9,   "mask_none_9",   2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        expect_at(r + 100, "mask_none_100", 2'b11, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_until(r + 101);

        // Repeated lock losses: the counter saturates at 255.
        applyStimulus(2'b11, 2'b11);
        reset_dut(r);
        for (int i = 0; i < 300; i++) begin
            k = 0;
            while (ready !== 1'b1 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL run_wait iteration %0d: ready=%b, required 1 within 100 cycles", i, ready);
            end
            applyStimulus(2'b11, 2'b00);
            wait_until(cyc + 4);
            if (i == 253) expect_at(cyc + 1, "loss_254", 2'b11, 1'b0, LOSS_FAIL, 2'd0, 8'd254);
            if (i == 299) expect_at(cyc + 1, "loss_sat", 2'b11, 1'b0, LOSS_FAIL, 2'd0, 8'd255);
            wait_until(cyc + 1);
`ifndef SDRAM_CLK_SUP_AUTO_RECOVER_EN
            clear_fail = 1'b1;
            wait_until(cyc + 1);
            clear_fail = 1'b0;
`endif
            applyStimulus(2'b11, 2'b11);
        end

        for (int j = 0; j < 20 && sb.size() > 0; j++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            checks += sb.size();
            errors += sb.size();
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_clk_supervisor.md
Name: sdram_clk_supervisor

Overview:
- Parametrised lock supervisor and reset sequencer for NUM_CH clock-manager (DCM/PLL) channels feeding the SDRAM controller and PHY.
- Drives each channel's reset, waits for lock with timeout, requires a stability window, then raises ready and the PHY clock-output enable.
- Retries bounded times, counts lock-loss events and latches a sticky fail. Clock primitives stay outside; this block is pure synchronous control.

Parameters:
- NUM_CH, 2, number of supervised clock-manager channels (1..8)
- RST_CYCLES, 8, reset pulse width in clk cycles (>=4, covers 2-flop sync latency)
- LOCK_TIMEOUT, 256, max cycles in WAIT_LOCK before a failure
- STABLE_CYCLES, 16, consecutive all-locked cycles required before RUN
- MAX_RETRY, 2, failures tolerated before FAIL
- CNT_W, 16, width of internal timers (must hold max of the three cycle parameters)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ch_enable  in  NUM_CH  channel mask; sampled only on exit from RESET
- locked_in  in  NUM_CH  raw LOCKED from clock managers (async; 2-flop synchronised internally)
- clear_fail  in  1  single-cycle pulse; leaves FAIL and restarts sequence
- dcm_rst  out  NUM_CH  per-channel clock-manager reset, active-high
- ready  out  1  all enabled channels locked and stable
- phy_clk_en  out  1  CE for the PHY clock ODDR; equals ready, registered
- fail  out  1  sticky failure flag
- retry_cnt  out  2  failures since last RUN entry
- lock_loss_cnt  out  8  RUN-state lock-loss events, saturating at 255

Behaviour:
- Reset values: dcm_rst all 1, ready 0, phy_clk_en 0, fail 0, retry_cnt 0, lock_loss_cnt 0, state RESET, timers 0.
- Sync: locked_s = 2-flop sync of locked_in (2-cycle latency). all_locked = &(locked_s | ~mask).
- mask is the registered copy of ch_enable, captured on the RESET->WAIT_LOCK edge. Disabled channels keep dcm_rst=1 in every state.
- RESET: dcm_rst=all 1, timer counts 0..RST_CYCLES-1. At terminal count:
  - if ch_enable==0, stay in RESET with timer restarted;
  - else latch mask and go to WAIT_LOCK.
- WAIT_LOCK: dcm_rst=~mask, timer counts from 0. all_locked -> STABLE. Timer reaches LOCK_TIMEOUT-1 without lock -> failure.
- STABLE: timer counts consecutive all_locked cycles. Any drop -> failure. After STABLE_CYCLES cycles -> RUN, with ready/phy_clk_en set on the same edge and retry_cnt cleared.
- RUN: ready=phy_clk_en=1. On an all_locked drop:
  - ready/phy_clk_en clear on the next edge;
  - lock_loss_cnt increments (saturating);
  - next state is set by the optional feature.
- Failure: if retry_cnt==MAX_RETRY -> FAIL; else retry_cnt++ and go to RESET.
- FAIL: dcm_rst all 1, fail=1, ready=0. clear_fail -> RESET with fail cleared, retry_cnt cleared, lock_loss_cnt kept. clear_fail is ignored outside FAIL.
- Simultaneous events: a timeout and lock on the same cycle count as lock (lock wins).
- rst mid-operation: immediate return to reset values, asynchronously.

Optional Feature:
- Macro: SDRAM_CLK_SUP_AUTO_RECOVER_EN.
- Defined: lock loss in RUN -> RESET, a full re-sequence; does not consume a retry.
- Undefined: lock loss in RUN -> FAIL directly; requires clear_fail.

Decomposition:
- Package sdram_clk_sup_pkg holds:
  - state encoding (RESET, WAIT_LOCK, STABLE, RUN, FAIL; 3 bits);
  - LOSS_CNT_W=8 and RETRY_W=2 constants;
  - a clog2 function for timer sizing checks.
- One sub-module, sdram_lock_sync: NUM_CH-wide 2-flop synchroniser with async reset to 0.

Test Plan (defaults unless stated):
- Bring-up: release rst, ch_enable=2'b11, locked_in=2'b11 from 4 cycles after dcm_rst falls -> dcm_rst high 8 cycles; ready rises exactly 18 cycles (STABLE_CYCLES+2) after locked_in first sampled high; retry_cnt=0.
- Timeout: locked_in stuck 0 -> three 256-cycle WAIT_LOCK windows with retry_cnt 1,2, then FAIL with fail=1 and dcm_rst=2'b11; clear_fail pulse -> RESET with fail=0 and retry_cnt=0.
- Stability glitch: lock, then ch0 drops for 1 cycle at STABLE cycle 10 -> retry_cnt=1, back to RESET, ready never asserted; a clean second attempt reaches RUN.
- Mask: ch_enable=2'b01, locked_in[1]=0 -> dcm_rst[1] stays 1 and RUN is reached on ch0 alone. ch_enable=0 -> stays in RESET indefinitely with ready=0.
- Lock loss in RUN: drop locked_in[0] -> lock_loss_cnt=1 and ready=0 two cycles later. With AUTO_RECOVER_EN the block re-enters RESET; without it, fail=1. After 300 losses, lock_loss_cnt reads 255.
- Async reset mid-STABLE: assert rst off-edge -> all outputs reach reset values before the next clk edge.
